// File: rtl/cga_isa_wrbuf_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cga_isa_wrbuf_if : ISA-side and VRAM-side bus of the write buffer |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface cga_isa_wrbuf_if #(
  parameter int ADDR_W = 19
) ();
  logic              mem_cs;
  logic              memw_l;
  logic              memr_l;
  logic [ADDR_W-1:0] isa_addr;
  logic [7:0]        isa_din;
  logic              isa_op_enable;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_dout;
  logic              vram_we;
  logic              vram_re;
  logic [7:0]        vram_rdata;
  logic [7:0]        rd_data;
  logic              bus_rdy;
  logic              ovf_err;

  modport master (
    output mem_cs, memw_l, memr_l, isa_addr, isa_din, isa_op_enable, vram_rdata,
    input  vram_addr, vram_dout, vram_we, vram_re, rd_data, bus_rdy, ovf_err
  );

  modport slave (
    input  mem_cs, memw_l, memr_l, isa_addr, isa_din, isa_op_enable, vram_rdata,
    output vram_addr, vram_dout, vram_we, vram_re, rd_data, bus_rdy, ovf_err
  );
endinterface
`default_nettype wire

// File: rtl/cga_isa_wrbuf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cga_isa_wrbuf : posted ISA write FIFO with read-after-drain path  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module cga_isa_wrbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 19
) (
  input  logic           clk,
  input  logic           rst,
  cga_isa_wrbuf_if.slave bus
);
  localparam int c_idx_w = $clog2(DEPTH);
  localparam int c_ptr_w = c_idx_w + 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_STALL   = 3'd1,
    S_RD_DRAIN   = 3'd2,
    S_RD_ISSUE   = 3'd3,
    S_RD_CAPTURE = 3'd4,
    S_RD_HOLD    = 3'd5
  } state_t;

  state_t             r_state;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [ADDR_W-1:0]  r_fifo_addr [DEPTH];
  logic [7:0]         r_fifo_data [DEPTH];
  logic [ADDR_W-1:0]  r_stall_addr;
  logic [7:0]         r_stall_data;
  logic               r_memw_prev;
  logic               r_memr_prev;
  logic               r_armed;
  logic               r_bus_rdy;
  logic               r_ovf_err;
  logic [7:0]         r_rd_data;

  logic               w_empty;
  logic               w_full;
  logic               w_wr_start;
  logic               w_rd_start;
  logic               w_pop;
  logic               w_push;
  logic               w_push_stall;
  logic               w_rd_issue;
  logic               w_drop;
  logic [c_idx_w-1:0] w_head;
  logic [ADDR_W-1:0]  w_push_addr;
  logic [7:0]         w_push_data;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_idx_w] != r_rptr[c_idx_w]) &&
                   (r_wptr[c_idx_w-1:0] == r_rptr[c_idx_w-1:0]);

  // r_armed masks the first cycle after reset so an already-low strobe is not an edge
  assign w_wr_start = r_armed & bus.mem_cs & ~bus.memw_l & r_memw_prev;
  assign w_rd_start = r_armed & bus.mem_cs & ~bus.memr_l & r_memr_prev;

  assign w_pop        = bus.isa_op_enable & ~w_empty & (r_state != S_RD_ISSUE);
  assign w_rd_issue   = bus.isa_op_enable & (r_state == S_RD_ISSUE);
  assign w_push_stall = (r_state == S_WR_STALL) & ~w_full;
  assign w_push       = w_push_stall | (w_wr_start & (r_state == S_IDLE) & ~w_full);
  assign w_drop       = w_wr_start & (r_state != S_IDLE);
  assign w_push_addr  = w_push_stall ? r_stall_addr : bus.isa_addr;
  assign w_push_data  = w_push_stall ? r_stall_data : bus.isa_din;
  assign w_head       = r_rptr[c_idx_w-1:0];

  assign bus.vram_we   = w_pop;
  assign bus.vram_re   = w_rd_issue;
  assign bus.vram_addr = w_rd_issue ? bus.isa_addr : r_fifo_addr[w_head];
  assign bus.vram_dout = r_fifo_data[w_head];
  assign bus.rd_data   = r_rd_data;
  assign bus.bus_rdy   = r_bus_rdy;
  assign bus.ovf_err   = r_ovf_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr[c_idx_w-1:0]] <= w_push_addr;
      r_fifo_data[r_wptr[c_idx_w-1:0]] <= w_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_stall_addr <= '0;
      r_stall_data <= '0;
      r_memw_prev  <= 1'b1;
      r_memr_prev  <= 1'b1;
      r_armed      <= 1'b0;
      r_bus_rdy    <= 1'b1;
      r_ovf_err    <= 1'b0;
      r_rd_data    <= 8'h00;
    end else begin
      r_memw_prev <= bus.memw_l;
      r_memr_prev <= bus.memr_l;
      r_armed     <= 1'b1;
      if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
      if (w_drop) r_ovf_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_rd_start) begin
            r_state   <= S_RD_DRAIN;
            r_bus_rdy <= 1'b0;
          end else if (w_wr_start && w_full) begin
            r_state      <= S_WR_STALL;
            r_bus_rdy    <= 1'b0;
            r_stall_addr <= bus.isa_addr;
            r_stall_data <= bus.isa_din;
          end
        end
        S_WR_STALL: begin
          if (!w_full) begin
            r_state   <= S_IDLE;
            r_bus_rdy <= 1'b1;
          end
        end
        // the read waits until every posted write has reached VRAM
        S_RD_DRAIN:   if (w_empty) r_state <= S_RD_ISSUE;
        S_RD_ISSUE:   if (bus.isa_op_enable) r_state <= S_RD_CAPTURE;
        S_RD_CAPTURE: begin
          r_rd_data <= bus.vram_rdata;
          r_bus_rdy <= 1'b1;
          r_state   <= S_RD_HOLD;
        end
        S_RD_HOLD:    if (bus.memr_l) r_state <= S_IDLE;
        default:      r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
